// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses a combinational instruction memory
// and registers the fetched word into IF/ID with stall, flush, redirect and halt control.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_DEPTH = 256,
  parameter int          IMEM_AW    = 8
) (
  input  logic               clk_CPU,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               flush,
  input  logic               branch_taken,
  input  logic [31:0]        branch_target,
  input  logic               jump,
  input  logic [31:0]        jump_target,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_data,
  output logic [31:0]        pc_out,
  output logic [31:0]        if_id_instr,
  output logic [31:0]        if_id_pc4,
  output logic               if_id_valid,
  output logic               halted,
  output logic               fault,
  output logic [31:0]        fault_pc,
  output logic [31:0]        fetch_count
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  localparam logic [31:0] MEM_BYTES = 32'(IMEM_DEPTH * 4);

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic [31:0] target;
  logic        redirect;
  logic        bad_target;
  logic        at_end;

  always_comb begin
    pc4        = pc + 32'd4;
    redirect   = jump | branch_taken;
    target     = jump ? jump_target : branch_target;
    bad_target = (target[1:0] != 2'b00) || (target >= MEM_BYTES);
    at_end     = (pc4 == MEM_BYTES);
  end

  assign imem_addr = pc[IMEM_AW+1:2];
  assign pc_out    = pc;

  always_ff @(posedge clk_CPU or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      if_id_instr <= 32'd0;
      if_id_pc4   <= 32'd0;
      if_id_valid <= 1'b0;
      halted      <= 1'b0;
      fault       <= 1'b0;
      fault_pc    <= 32'd0;
      fetch_count <= 32'd0;
    end else begin
      case (state)
        BOOT: begin
          state       <= RUN;
          if_id_instr <= 32'd0;
          if_id_pc4   <= 32'd0;
          if_id_valid <= 1'b0;
        end
        RUN: begin
          if (redirect) begin
            // The word fetched this cycle is wrong-path, so it never reaches IF/ID.
            if_id_instr <= 32'd0;
            if_id_pc4   <= 32'd0;
            if_id_valid <= 1'b0;
            if (bad_target) begin
              state    <= HALT;
              halted   <= 1'b1;
              fault    <= 1'b1;
              fault_pc <= target;
            end else begin
              pc <= target;
            end
          end else if (flush) begin
            if_id_instr <= 32'd0;
            if_id_pc4   <= 32'd0;
            if_id_valid <= 1'b0;
            // Stepping past the last word would wrap the memory index, so stop instead.
            if (!stall) begin
              if (at_end) begin
                state  <= HALT;
                halted <= 1'b1;
              end else begin
                pc <= pc4;
              end
            end
          end else if (!stall) begin
            if_id_instr <= imem_data;
            if_id_pc4   <= pc4;
            if_id_valid <= 1'b1;
            if (fetch_count != 32'hFFFF_FFFF) fetch_count <= fetch_count + 32'd1;
            if (at_end) begin
              state  <= HALT;
              halted <= 1'b1;
            end else begin
              pc <= pc4;
            end
          end
        end
        HALT: begin
          if_id_instr <= 32'd0;
          if_id_pc4   <= 32'd0;
          if_id_valid <= 1'b0;
        end
        default: begin
          state  <= HALT;
          halted <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a vector table plus hand-written corner sequences,
// with expected IF/ID and status values queued at drive time and popped after each edge.
module tb_fetch_stage;

  logic        clk_CPU = 1'b0;
  logic        rst_n;
  logic        stall, flush, branch_taken, jump;
  logic [31:0] branch_target, jump_target;
  logic [7:0]  imem_addr;
  logic [31:0] imem_data;
  logic [31:0] pc_out, if_id_instr, if_id_pc4, fault_pc, fetch_count;
  logic        if_id_valid, halted, fault;

  logic [31:0] imem [256];

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic        st, fl, br;
    logic [31:0] bt;
    logic        jp;
    logic [31:0] jt;
    logic [31:0] e_pc, e_instr, e_pc4;
    logic        e_valid, e_halted, e_fault;
    logic [31:0] e_fpc, e_cnt;
  } vec_t;

  vec_t exp_q [$];
  vec_t tbl [16];

  fetch_stage dut (
    .clk_CPU      (clk_CPU),
    .rst_n        (rst_n),
    .stall        (stall),
    .flush        (flush),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump         (jump),
    .jump_target  (jump_target),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .pc_out       (pc_out),
    .if_id_instr  (if_id_instr),
    .if_id_pc4    (if_id_pc4),
    .if_id_valid  (if_id_valid),
    .halted       (halted),
    .fault        (fault),
    .fault_pc     (fault_pc),
    .fetch_count  (fetch_count)
  );

  always #5 clk_CPU = ~clk_CPU;

  assign imem_data = imem[imem_addr];

  function automatic vec_t mk(input logic st, input logic fl, input logic br, input logic [31:0] bt,
                              input logic jp, input logic [31:0] jt, input logic [31:0] pc,
                              input logic [31:0] instr, input logic [31:0] pc4, input logic v,
                              input logic h, input logic f, input logic [31:0] fpc,
                              input logic [31:0] cnt);
    vec_t r;
    r.st = st; r.fl = fl; r.br = br; r.bt = bt; r.jp = jp; r.jt = jt;
    r.e_pc = pc; r.e_instr = instr; r.e_pc4 = pc4; r.e_valid = v;
    r.e_halted = h; r.e_fault = f; r.e_fpc = fpc; r.e_cnt = cnt;
    return r;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    stall = v.st; flush = v.fl; branch_taken = v.br; branch_target = v.bt;
    jump = v.jp; jump_target = v.jt;
    exp_q.push_back(v);
    @(posedge clk_CPU);
    #1;
  endtask

  task automatic checkOutput(input string tag);
    vec_t e;
    if (exp_q.size() == 0) begin
      cmp({tag, " queue"}, 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    cmp({tag, " pc"},        pc_out,             e.e_pc);
    cmp({tag, " imem_addr"}, 32'(imem_addr),     32'(e.e_pc[9:2]));
    cmp({tag, " instr"},     if_id_instr,        e.e_instr);
    cmp({tag, " valid"},     32'(if_id_valid),   32'(e.e_valid));
    if (e.e_valid) cmp({tag, " pc4"}, if_id_pc4, e.e_pc4);
    cmp({tag, " halted"},    32'(halted),        32'(e.e_halted));
    cmp({tag, " fault"},     32'(fault),         32'(e.e_fault));
    cmp({tag, " fault_pc"},  fault_pc,           e.e_fpc);
    cmp({tag, " count"},     fetch_count,        e.e_cnt);
  endtask

  task automatic step(input vec_t v, input string tag);
    applyStimulus(v);
    checkOutput(tag);
  endtask

  task automatic checkReset(input string tag);
    cmp({tag, " rst pc"},     pc_out,           32'd0);
    cmp({tag, " rst instr"},  if_id_instr,      32'd0);
    cmp({tag, " rst pc4"},    if_id_pc4,        32'd0);
    cmp({tag, " rst valid"},  32'(if_id_valid), 32'd0);
    cmp({tag, " rst halted"}, 32'(halted),      32'd0);
    cmp({tag, " rst fault"},  32'(fault),       32'd0);
    cmp({tag, " rst fpc"},    fault_pc,         32'd0);
    cmp({tag, " rst count"},  fetch_count,      32'd0);
  endtask

  // Assert reset between edges, check the asynchronous clear, then release on a falling edge.
  task automatic midReset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    checkReset(tag);
    @(negedge clk_CPU);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = 32'hC000_0000 + 32'(i);
    imem[0] = 32'h2008_0001;
    imem[1] = 32'h2009_0002;
    imem[2] = 32'h0109_5020;
    imem[3] = 32'h0000_0000;

    //            st fl br bt          jp jt          pc          instr         pc4    v  h  f  fpc cnt
    tbl[0]  = mk(0, 0, 0, 0,          0, 0,          32'h00, 32'h0,         0,     0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0,          0, 0,          32'h04, 32'h2008_0001, 32'h04, 1, 0, 0, 0, 1);
    tbl[2]  = mk(0, 0, 0, 0,          0, 0,          32'h08, 32'h2009_0002, 32'h08, 1, 0, 0, 0, 2);
    tbl[3]  = mk(1, 0, 0, 0,          0, 0,          32'h08, 32'h2009_0002, 32'h08, 1, 0, 0, 0, 2);
    tbl[4]  = mk(1, 0, 0, 0,          0, 0,          32'h08, 32'h2009_0002, 32'h08, 1, 0, 0, 0, 2);
    tbl[5]  = mk(1, 0, 0, 0,          0, 0,          32'h08, 32'h2009_0002, 32'h08, 1, 0, 0, 0, 2);
    tbl[6]  = mk(0, 0, 0, 0,          0, 0,          32'h0C, 32'h0109_5020, 32'h0C, 1, 0, 0, 0, 3);
    tbl[7]  = mk(0, 0, 1, 32'h20,     0, 0,          32'h20, 32'h0,         0,      0, 0, 0, 0, 3);
    tbl[8]  = mk(0, 0, 0, 0,          0, 0,          32'h24, 32'hC000_0008, 32'h24, 1, 0, 0, 0, 4);
    tbl[9]  = mk(0, 0, 1, 32'h20,     1, 32'h40,     32'h40, 32'h0,         0,      0, 0, 0, 0, 4);
    tbl[10] = mk(0, 0, 0, 0,          0, 0,          32'h44, 32'hC000_0010, 32'h44, 1, 0, 0, 0, 5);
    tbl[11] = mk(0, 1, 0, 0,          0, 0,          32'h48, 32'h0,         0,      0, 0, 0, 0, 5);
    tbl[12] = mk(1, 1, 0, 0,          0, 0,          32'h48, 32'h0,         0,      0, 0, 0, 0, 5);
    tbl[13] = mk(0, 0, 0, 0,          0, 0,          32'h4C, 32'hC000_0012, 32'h4C, 1, 0, 0, 0, 6);
    tbl[14] = mk(1, 0, 1, 32'h10,     0, 0,          32'h10, 32'h0,         0,      0, 0, 0, 0, 6);
    tbl[15] = mk(0, 0, 0, 0,          0, 0,          32'h14, 32'hC000_0004, 32'h14, 1, 0, 0, 0, 7);

    rst_n = 1'b0;
    stall = 0; flush = 0; branch_taken = 0; jump = 0; branch_target = 0; jump_target = 0;
    #12;
    checkReset("power-on");
    @(negedge clk_CPU);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) step(tbl[i], $sformatf("vec%0d", i));

    // Misaligned jump faults and then ignores every input.
    step(mk(0, 0, 0, 0,      1, 32'h6,   32'h14, 0, 0, 0, 1, 1, 32'h6, 7), "misaligned");
    step(mk(0, 0, 1, 32'h20, 1, 32'h100, 32'h14, 0, 0, 0, 1, 1, 32'h6, 7), "halt-hold1");
    step(mk(1, 1, 0, 0,      0, 0,       32'h14, 0, 0, 0, 1, 1, 32'h6, 7), "halt-hold2");

    midReset("mid-halt");
    step(mk(0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0), "boot2");
    step(mk(0, 0, 0, 0, 0, 0, 32'h4, 32'h2008_0001, 32'h4, 1, 0, 0, 0, 1), "restart");

    // Jump to the first byte past memory is out of range.
    step(mk(0, 0, 0, 0,      1, 32'h400, 32'h4, 0, 0, 0, 1, 1, 32'h400, 1), "range");
    step(mk(0, 0, 1, 32'h8,  0, 0,       32'h4, 0, 0, 0, 1, 1, 32'h400, 1), "range-hold");

    midReset("mid-halt2");
    step(mk(0, 0, 0, 0, 0, 0,        32'h0,   0, 0, 0, 0, 0, 0, 0), "boot3");
    step(mk(0, 0, 0, 0, 1, 32'h3F8,  32'h3F8, 0, 0, 0, 0, 0, 0, 0), "to-end");
    step(mk(0, 0, 0, 0, 0, 0, 32'h3FC, 32'hC000_00FE, 32'h3FC, 1, 0, 0, 0, 1), "word254");
    step(mk(0, 0, 0, 0, 0, 0, 32'h3FC, 32'hC000_00FF, 32'h400, 1, 1, 0, 0, 2), "word255");
    step(mk(0, 0, 0, 0, 0, 0, 32'h3FC, 0, 0, 0, 1, 0, 0, 2), "end-halt");
    step(mk(0, 0, 1, 32'h0, 0, 0, 32'h3FC, 0, 0, 0, 1, 0, 0, 2), "end-hold");

    midReset("mid-halt3");
    step(mk(0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0), "boot4");
    step(mk(0, 0, 0, 0, 0, 0, 32'h4, 32'h2008_0001, 32'h4, 1, 0, 0, 0, 1), "pre-stall");
    step(mk(1, 0, 0, 0, 0, 0, 32'h4, 32'h2008_0001, 32'h4, 1, 0, 0, 0, 1), "stalled");
    midReset("mid-stall");
    step(mk(0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0), "boot5");
    step(mk(0, 0, 0, 0, 0, 0, 32'h4, 32'h2008_0001, 32'h4, 1, 0, 0, 0, 1), "restart2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
